// File: rtl/cfo_corrector.sv
// Carrier-frequency-offset de-rotator: phase accumulator, sin/cos ROM and complex multiply.
// Latency 4 cycles input-beat to output-beat, one sample per clock; no backpressure.
module cfo_corrector #(
  parameter int IN_DW  = 32,
  parameter int OUT_DW = 32,
  parameter int DDS_DW = 20,
  parameter int LUT_AW = 10,
  parameter int LUT_DW = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [IN_DW-1:0]  s_axis_in_tdata,
  input  logic              s_axis_in_tvalid,
  input  logic [DDS_DW-1:0] CFO_DDS_inc_i,
  input  logic              CFO_valid_i,
  input  logic              reset_phase_i,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  output logic [DDS_DW-1:0] phase_o
);

  localparam int HW   = IN_DW / 2;
  localparam int OW   = OUT_DW / 2;
  localparam int PW   = HW + LUT_DW;
  localparam int NLUT = 2 ** LUT_AW;

  // Elaboration-time Taylor series keeps the ROM generator free of math-library calls.
  function automatic real taylor(input real x, input bit is_sin);
    real term;
    real sum;
    int  n0;
    n0   = is_sin ? 1 : 0;
    term = is_sin ? x : 1.0;
    sum  = term;
    for (int i = 1; i <= 14; i++) begin
      term = -term * x * x / (real'(n0 + 2 * i - 1) * real'(n0 + 2 * i));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic logic [NLUT*LUT_DW-1:0] build_lut(input bit is_sin);
    logic [NLUT*LUT_DW-1:0] tbl;
    real ang;
    real amp;
    real v;
    int  q;
    tbl = '0;
    amp = real'((2 ** (LUT_DW - 1)) - 1);
    for (int k = 0; k < NLUT; k++) begin
      ang = 6.283185307179586 * real'(k) / real'(NLUT);
      if (ang > 3.141592653589793) ang = ang - 6.283185307179586;
      v = amp * taylor(ang, is_sin);
      q = $rtoi((v >= 0.0) ? (v + 0.5) : (v - 0.5));
      tbl[k*LUT_DW +: LUT_DW] = q[LUT_DW-1:0];
    end
    return tbl;
  endfunction

  localparam logic [NLUT*LUT_DW-1:0] COS_TBL = build_lut(1'b0);
  localparam logic [NLUT*LUT_DW-1:0] SIN_TBL = build_lut(1'b1);

  localparam logic signed [PW:0] RND     = (PW + 1)'(2 ** (LUT_DW - 2));
  localparam logic signed [PW:0] SAT_MAX = {{(PW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [PW:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [OW-1:0] sat(input logic signed [PW:0] v);
    if (v > SAT_MAX)      return SAT_MAX[OW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[OW-1:0];
    else                  return v[OW-1:0];
  endfunction

  logic [DDS_DW-1:0]        r_acc, r_inc;
  logic                     r_s1_vld, r_s2_vld, r_s3_vld, r_out_vld;
  logic signed [HW-1:0]     r_s1_re, r_s1_im, r_s2_re, r_s2_im;
  logic [LUT_AW-1:0]        r_s1_addr;
  logic signed [LUT_DW-1:0] r_cos, r_sin;
  logic signed [PW-1:0]     r_p_rc, r_p_is, r_p_ic, r_p_rs;
  logic signed [OW-1:0]     r_out_re, r_out_im;

  logic [DDS_DW-1:0]        w_step;
  logic signed [PW:0]       w_sum_re, w_sum_im, w_sh_re, w_sh_im;

  assign w_step   = CFO_valid_i ? CFO_DDS_inc_i : r_inc;
  assign w_sum_re = (PW + 1)'(r_p_rc) + (PW + 1)'(r_p_is) + RND;
  assign w_sum_im = (PW + 1)'(r_p_ic) - (PW + 1)'(r_p_rs) + RND;
  assign w_sh_re  = w_sum_re >>> (LUT_DW - 1);
  assign w_sh_im  = w_sum_im >>> (LUT_DW - 1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_acc     <= '0;
      r_inc     <= '0;
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s3_vld  <= 1'b0;
      r_out_vld <= 1'b0;
      r_s1_re   <= '0;
      r_s1_im   <= '0;
      r_s1_addr <= '0;
      r_s2_re   <= '0;
      r_s2_im   <= '0;
      r_cos     <= '0;
      r_sin     <= '0;
      r_p_rc    <= '0;
      r_p_is    <= '0;
      r_p_ic    <= '0;
      r_p_rs    <= '0;
      r_out_re  <= '0;
      r_out_im  <= '0;
    end else begin
      if (CFO_valid_i) r_inc <= CFO_DDS_inc_i;
      // Phase clear wins over the step; the beat in this cycle already took the old phase.
      if (reset_phase_i)         r_acc <= '0;
      else if (s_axis_in_tvalid) r_acc <= r_acc + w_step;

      r_s1_vld  <= s_axis_in_tvalid;
      r_s1_re   <= s_axis_in_tdata[HW-1:0];
      r_s1_im   <= s_axis_in_tdata[IN_DW-1:HW];
      r_s1_addr <= r_acc[DDS_DW-1 -: LUT_AW];

      r_s2_vld  <= r_s1_vld;
      r_s2_re   <= r_s1_re;
      r_s2_im   <= r_s1_im;
      r_cos     <= COS_TBL[int'(r_s1_addr)*LUT_DW +: LUT_DW];
      r_sin     <= SIN_TBL[int'(r_s1_addr)*LUT_DW +: LUT_DW];

      r_s3_vld  <= r_s2_vld;
      r_p_rc    <= PW'(r_s2_re) * PW'(r_cos);
      r_p_is    <= PW'(r_s2_im) * PW'(r_sin);
      r_p_ic    <= PW'(r_s2_im) * PW'(r_cos);
      r_p_rs    <= PW'(r_s2_re) * PW'(r_sin);

      r_out_vld <= r_s3_vld;
      r_out_re  <= sat(w_sh_re);
      r_out_im  <= sat(w_sh_im);
    end
  end

  assign m_axis_out_tdata  = {r_out_im, r_out_re};
  assign m_axis_out_tvalid = r_out_vld;
  assign phase_o           = r_acc;

endmodule

// File: tb/tb_cfo_corrector.sv
// Directed bench for cfo_corrector: per-cycle expected output table, checked on falling edges.
module tb_cfo_corrector;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] s_axis_in_tdata = '0;
  logic        s_axis_in_tvalid = 1'b0;
  logic [19:0] CFO_DDS_inc_i = '0;
  logic        CFO_valid_i = 1'b0;
  logic        reset_phase_i = 1'b0;
  logic [31:0] m_axis_out_tdata;
  logic        m_axis_out_tvalid;
  logic [19:0] phase_o;

  cfo_corrector dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .s_axis_in_tdata(s_axis_in_tdata), .s_axis_in_tvalid(s_axis_in_tvalid),
    .CFO_DDS_inc_i(CFO_DDS_inc_i), .CFO_valid_i(CFO_valid_i), .reset_phase_i(reset_phase_i),
    .m_axis_out_tdata(m_axis_out_tdata), .m_axis_out_tvalid(m_axis_out_tvalid),
    .phase_o(phase_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;
  bit exp_vld [0:2047];
  int exp_re  [0:2047];
  int exp_im  [0:2047];

  localparam int Q = 262144;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (mon_en) begin
      check($sformatf("tvalid@%0d", cyc), longint'(m_axis_out_tvalid), longint'(exp_vld[cyc]));
      if (exp_vld[cyc] && m_axis_out_tvalid) begin
        check($sformatf("re@%0d", cyc), longint'($signed(m_axis_out_tdata[15:0])), exp_re[cyc]);
        check($sformatf("im@%0d", cyc), longint'($signed(m_axis_out_tdata[31:16])), exp_im[cyc]);
      end
    end
  end

  // Called on a falling edge; drives one cycle and returns on the next falling edge.
  task automatic drive(input bit v, input int re, input int im, input int ere, input int eim,
                       input bit cfo, input int inc, input bit rph);
    s_axis_in_tvalid = v;
    s_axis_in_tdata  = {16'(im), 16'(re)};
    CFO_valid_i      = cfo;
    CFO_DDS_inc_i    = 20'(inc);
    reset_phase_i    = rph;
    if (v) begin
      exp_vld[cyc + 4] = 1'b1;
      exp_re[cyc + 4]  = ere;
      exp_im[cyc + 4]  = eim;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    s_axis_in_tvalid = 1'b0;
    CFO_valid_i      = 1'b0;
    reset_phase_i    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic beat(input int re, input int im, input int ere, input int eim);
    drive(1'b1, re, im, ere, eim, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int qre [4];
    int qim [4];
    qre = '{1000, 0, -1000, 0};
    qim = '{0, -1000, 0, 1000};
    for (int i = 0; i < 2048; i++) begin
      exp_vld[i] = 1'b0; exp_re[i] = 0; exp_im[i] = 0;
    end

    // Reset state
    @(posedge clk_i);
    @(negedge clk_i);
    mon_en = 1'b1;
    check("rst_tdata", longint'(m_axis_out_tdata), 0);
    check("rst_phase", longint'(phase_o), 0);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Unity phase
    for (int i = 0; i < 8; i++) beat(1000, 0, 1000, 0);
    check("t1_phase", longint'(phase_o), 0);
    idle(5);

    // Quarter-turn rotation; accumulator wraps every 4 beats
    drive(1'b0, 0, 0, 0, 0, 1'b1, Q, 1'b0);
    for (int k = 0; k < 8; k++) begin
      beat(1000, 0, qre[k % 4], qim[k % 4]);
      check($sformatf("t2_phase%0d", k), longint'(phase_o), longint'(((k + 1) * Q) % 1048576));
    end
    idle(5);

    // Increment change mid-stream and valid gap
    drive(1'b0, 0, 0, 0, 0, 1'b1, 0, 1'b1);
    for (int k = 0; k < 5; k++) beat(300, 700, 300, 700);
    check("t3_phase_hold", longint'(phase_o), 0);
    drive(1'b1, 300, 700, 300, 700, 1'b1, Q, 1'b0);
    beat(300, 700, 700, -300);
    beat(300, 700, -300, -700);
    idle(3);
    check("t3_gap_phase", longint'(phase_o), 3 * Q);
    beat(300, 700, -700, 300);
    idle(5);

    // Phase clear with a sample present
    drive(1'b0, 0, 0, 0, 0, 1'b1, Q, 1'b1);
    for (int k = 0; k < 3; k++) beat(1000, 0, qre[k], qim[k]);
    check("t4_phase_pre", longint'(phase_o), 786432);
    drive(1'b1, 1000, 0, 0, 1000, 1'b0, 0, 1'b1);
    check("t4_phase_clr", longint'(phase_o), 0);
    beat(1000, 0, 1000, 0);
    beat(1000, 0, 0, -1000);
    idle(5);

    // Saturation at 1/8 turn
    drive(1'b0, 0, 0, 0, 0, 1'b1, 131072, 1'b1);
    beat(1000, 0, 1000, 0);
    check("t5_phase", longint'(phase_o), 131072);
    beat(-32768, -32768, -32768, 0);
    idle(5);

    // Reset with samples in flight
    for (int k = 0; k < 3; k++) beat(1000, 0, 0, 0);
    reset_i = 1'b1;
    for (int i = 1; i <= 4; i++) exp_vld[cyc + i] = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    check("t6_phase_rst", longint'(phase_o), 0);
    beat(500, 0, 500, 0);
    beat(500, 0, 500, 0);
    check("t6_inc_zero", longint'(phase_o), 0);
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
